// File: rtl/alu_multicycle_pkg.sv
// rtl/alu_multicycle_pkg.sv - op codes, FSM states and flag bit positions for alu_multicycle
package alu_multicycle_pkg;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_AND = 4'd2;
    localparam logic [3:0] OP_OR  = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4;
    localparam logic [3:0] OP_SHL = 4'd5;
    localparam logic [3:0] OP_SHR = 4'd6;
    localparam logic [3:0] OP_SAR = 4'd7;
    localparam logic [3:0] OP_MUL = 4'd8;
    localparam logic [3:0] OP_DIV = 4'd9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // fout = {ill, dz, n, z, c, v}
    localparam int F_V   = 0;
    localparam int F_C   = 1;
    localparam int F_Z   = 2;
    localparam int F_N   = 3;
    localparam int F_DZ  = 4;
    localparam int F_ILL = 5;

endpackage

// File: rtl/alu_multicycle_iter.sv
// rtl/alu_multicycle_iter.sv - iterative shift-add multiply / restoring divide, one bit per step
// Divide path present only when ALU_MULTICYCLE_DIV_EN is defined.
module alu_multicycle_iter
    import alu_multicycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_div,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             last,
    output logic [WIDTH-1:0] res_lo,
    output logic [WIDTH-1:0] res_hi
);

    localparam int SW = $clog2(WIDTH);

    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] bop;
    logic [SW-1:0]    cnt;
    logic [WIDTH+1:0] add_x;
    logic [WIDTH+1:0] add_y;
    logic [WIDTH+1:0] add_s;
    logic             add_cin;
    logic [WIDTH-1:0] hi_nx;
    logic [WIDTH-1:0] lo_nx;

`ifdef ALU_MULTICYCLE_DIV_EN
    logic div_mode;
`else
    logic unused_div;
    logic unused_msb;
    assign unused_div = is_div;
    assign unused_msb = add_s[WIDTH+1];
`endif

    // One shared adder: hi + (b & lo[0]) for multiply, {hi,lo_msb} - b for divide.
    always_comb begin
        add_x   = {2'b00, hi};
        add_y   = {2'b00, bop & {WIDTH{lo[0]}}};
        add_cin = 1'b0;
`ifdef ALU_MULTICYCLE_DIV_EN
        if (div_mode) begin
            add_x   = {1'b0, hi, lo[WIDTH-1]};
            add_y   = ~{2'b00, bop};
            add_cin = 1'b1;
        end
`endif
        add_s = add_x + add_y + {{(WIDTH+1){1'b0}}, add_cin};
        hi_nx = add_s[WIDTH:1];
        lo_nx = {add_s[0], lo[WIDTH-1:1]};
`ifdef ALU_MULTICYCLE_DIV_EN
        if (div_mode) begin
            hi_nx = add_s[WIDTH+1] ? {hi[WIDTH-2:0], lo[WIDTH-1]} : add_s[WIDTH-1:0];
            lo_nx = {lo[WIDTH-2:0], ~add_s[WIDTH+1]};
        end
`endif
    end

    assign last   = (cnt == SW'(WIDTH - 1));
    assign res_lo = lo_nx;
    assign res_hi = hi_nx;

    always_ff @(posedge clk) begin
        if (rst) begin
            hi  <= '0;
            lo  <= '0;
            bop <= '0;
            cnt <= '0;
`ifdef ALU_MULTICYCLE_DIV_EN
            div_mode <= 1'b0;
`endif
        end else if (start) begin
            hi  <= '0;
            lo  <= a;
            bop <= b;
            cnt <= '0;
`ifdef ALU_MULTICYCLE_DIV_EN
            div_mode <= is_div;
`endif
        end else if (step) begin
            hi  <= hi_nx;
            lo  <= lo_nx;
            cnt <= cnt + SW'(1);
        end
    end

endmodule

// File: rtl/alu_multicycle.sv
// rtl/alu_multicycle.sv - valid/ready ALU: single-cycle logic/arith/shift, iterative MUL and DIV
// Define ALU_MULTICYCLE_DIV_EN to build the divider; otherwise DIV decodes as illegal.
module alu_multicycle
    import alu_multicycle_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] q0,
    output logic [WIDTH-1:0] q1,
    output logic [5:0]       fout
);

    localparam int SW = $clog2(WIDTH);

    state_t           state;
    logic             op_mul;
    logic             accept;
    logic             is_iter;
    logic             known;
    logic [WIDTH-1:0] sc_q0;
    logic [WIDTH-1:0] sc_q1;
    logic [5:0]       sc_flags;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   sh_w;
    logic [SW-1:0]    sh;
    logic             iter_last;
    logic [WIDTH-1:0] res_lo;
    logic [WIDTH-1:0] res_hi;
    logic [5:0]       it_flags;

    assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && in_ready;
    assign sh        = b[SW-1:0];

    // Shifts run one bit wider so the last bit shifted out lands in the spare bit.
    always_comb begin
        sc_q0    = '0;
        sc_q1    = '0;
        sc_flags = '0;
        sum      = '0;
        sh_w     = '0;
        is_iter  = 1'b0;
        known    = 1'b1;
        case (op)
            OP_ADD: begin
                sum = {1'b0, a} + {1'b0, b};
                sc_q0 = sum[WIDTH-1:0];
                sc_flags[F_C] = sum[WIDTH];
                sc_flags[F_V] = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                sum = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
                sc_q0 = sum[WIDTH-1:0];
                sc_flags[F_C] = sum[WIDTH];
                sc_flags[F_V] = (a[WIDTH-1] != b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: sc_q0 = a & b;
            OP_OR:  sc_q0 = a | b;
            OP_XOR: sc_q0 = a ^ b;
            OP_SHL: begin
                sh_w = {1'b0, a} << sh;
                sc_q0 = sh_w[WIDTH-1:0];
                sc_flags[F_C] = sh_w[WIDTH];
            end
            OP_SHR: begin
                sh_w = {a, 1'b0} >> sh;
                sc_q0 = sh_w[WIDTH:1];
                sc_flags[F_C] = sh_w[0];
            end
            OP_SAR: begin
                sh_w = $signed({a, 1'b0}) >>> sh;
                sc_q0 = sh_w[WIDTH:1];
                sc_flags[F_C] = sh_w[0];
            end
            OP_MUL: is_iter = 1'b1;
`ifdef ALU_MULTICYCLE_DIV_EN
            OP_DIV: begin
                if (b == '0) begin
                    sc_q0 = '1;
                    sc_q1 = a;
                    sc_flags[F_DZ] = 1'b1;
                end else begin
                    is_iter = 1'b1;
                end
            end
`endif
            default: begin
                known = 1'b0;
                sc_flags[F_ILL] = 1'b1;
            end
        endcase
        if (known) begin
            sc_flags[F_N] = sc_q0[WIDTH-1];
            sc_flags[F_Z] = (sc_q0 == '0);
        end
    end

    alu_multicycle_iter #(.WIDTH(WIDTH)) u_iter (
        .clk    (clk),
        .rst    (rst),
        .start  (accept && is_iter),
        .is_div (op == OP_DIV),
        .step   (state == BUSY),
        .a      (a),
        .b      (b),
        .last   (iter_last),
        .res_lo (res_lo),
        .res_hi (res_hi)
    );

    always_comb begin
        it_flags = '0;
        if (op_mul) begin
            it_flags[F_N] = res_hi[WIDTH-1];
            it_flags[F_Z] = (res_hi == '0) && (res_lo == '0);
            it_flags[F_C] = |res_hi;
            it_flags[F_V] = |res_hi;
        end else begin
            it_flags[F_N] = res_lo[WIDTH-1];
            it_flags[F_Z] = (res_lo == '0);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            q0     <= '0;
            q1     <= '0;
            fout   <= '0;
            op_mul <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        op_mul <= (op == OP_MUL);
                        if (is_iter) begin
                            state <= BUSY;
                        end else begin
                            state <= DONE;
                            q0    <= sc_q0;
                            q1    <= sc_q1;
                            fout  <= sc_flags;
                        end
                    end else if (state == DONE && out_ready) begin
                        state <= IDLE;
                    end
                end
                BUSY: begin
                    if (iter_last) begin
                        state <= DONE;
                        q0    <= res_lo;
                        q1    <= res_hi;
                        fout  <= it_flags;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// tb/tb_alu_multicycle.sv - self-checking bench for alu_multicycle against a behavioural model
module tb_alu_multicycle;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  op = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] q0;
    logic [31:0] q1;
    logic [5:0]  fout;

    int total = 0;
    int bad = 0;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .q0(q0), .q1(q1), .fout(fout)
    );

    always #5 clk = ~clk;

    task automatic model(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                         output logic [31:0] e0, output logic [31:0] e1,
                         output logic [5:0] ef, output int el);
        logic [63:0] u;
        longint s;
        int sh;
        logic ill, dz, n, z, c, v;
        ill = 0; dz = 0; c = 0; v = 0; n = 0; z = 0;
        e0 = 0; e1 = 0; el = 1;
        sh = int'(y[4:0]);
        case (o)
            4'd0: begin
                u = 64'(x) + 64'(y);
                e0 = u[31:0]; c = u[32];
                s = longint'($signed(x)) + longint'($signed(y));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd1: begin
                e0 = x - y; c = (x >= y);
                s = longint'($signed(x)) - longint'($signed(y));
                v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
            end
            4'd2: e0 = x & y;
            4'd3: e0 = x | y;
            4'd4: e0 = x ^ y;
            4'd5: begin e0 = x << sh; c = (sh == 0) ? 1'b0 : x[32-sh]; end
            4'd6: begin e0 = x >> sh; c = (sh == 0) ? 1'b0 : x[sh-1]; end
            4'd7: begin e0 = $signed(x) >>> sh; c = (sh == 0) ? 1'b0 : x[sh-1]; end
            4'd8: begin
                u = 64'(x) * 64'(y);
                e0 = u[31:0]; e1 = u[63:32];
                c = (e1 != 0); v = c; el = 33;
            end
`ifdef ALU_MULTICYCLE_DIV_EN
            4'd9: begin
                if (y == 0) begin
                    e0 = 32'hFFFF_FFFF; e1 = x; dz = 1;
                end else begin
                    e0 = x / y; e1 = x % y; el = 33;
                end
            end
`endif
            default: ill = 1;
        endcase
        if (!ill) begin
            n = (o == 4'd8) ? e1[31] : e0[31];
            z = (o == 4'd8) ? ({e1, e0} == 64'd0) : (e0 == 0);
        end
        ef = {ill, dz, n, z, c, v};
    endtask

    task automatic run_op(input logic [3:0] o, input logic [31:0] x, input logic [31:0] y,
                          output logic [31:0] r0, output logic [31:0] r1,
                          output logic [5:0] rf, output int lat);
        int guard;
        guard = 0;
        while (!in_ready && guard < 100) begin @(posedge clk); #1; guard++; end
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        r0 = q0; r1 = q1; rf = fout;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [3:0] o,
                            input logic [31:0] x, input logic [31:0] y);
        logic [31:0] r0, r1, e0, e1;
        logic [5:0] rf, ef;
        int lat, el;
        model(o, x, y, e0, e1, ef, el);
        run_op(o, x, y, r0, r1, rf, lat);
        total++;
        if ({r0, r1, rf} !== {e0, e1, ef}) begin
            bad++;
            $display("FAIL %s result: op=%0d a=%h b=%h got q0=%h q1=%h f=%b want q0=%h q1=%h f=%b",
                     name, o, x, y, r0, r1, rf, e0, e1, ef);
        end
        total++;
        if (lat !== el) begin
            bad++;
            $display("FAIL %s latency: op=%0d got %0d want %0d", name, o, lat, el);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({q0, q1, fout, out_valid, in_ready} !== {32'd0, 32'd0, 6'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL reset_state: got q0=%h q1=%h f=%b ov=%b ir=%b want zeros ov=0 ir=1",
                     q0, q1, fout, out_valid, in_ready);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_directed();
        logic [31:0] r0, r1;
        logic [5:0] rf;
        int lat;
        run_op(4'd0, 32'h7FFF_FFFF, 32'd1, r0, r1, rf, lat);
        total++;
        if ({r0, rf, lat} !== {32'h8000_0000, 6'b001001, 32'd1}) begin
            bad++;
            $display("FAIL add_ovf: got q0=%h f=%b lat=%0d want 80000000 001001 1", r0, rf, lat);
        end
        run_op(4'd1, 32'd5, 32'd5, r0, r1, rf, lat);
        total++;
        if ({r0, rf} !== {32'd0, 6'b000110}) begin
            bad++;
            $display("FAIL sub_eq: got q0=%h f=%b want 0 000110", r0, rf);
        end
        run_op(4'd7, 32'h8000_0000, 32'd4, r0, r1, rf, lat);
        total++;
        if ({r0, rf} !== {32'hF800_0000, 6'b001000}) begin
            bad++;
            $display("FAIL sar: got q0=%h f=%b want f8000000 001000", r0, rf);
        end
        run_op(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r0, r1, rf, lat);
        total++;
        if ({r1, r0, rf, lat} !== {32'hFFFF_FFFE, 32'h0000_0001, 6'b001011, 32'd33}) begin
            bad++;
            $display("FAIL mul_max: got q1=%h q0=%h f=%b lat=%0d want fffffffe 00000001 001011 33",
                     r1, r0, rf, lat);
        end
`ifdef ALU_MULTICYCLE_DIV_EN
        run_op(4'd9, 32'd100, 32'd7, r0, r1, rf, lat);
        total++;
        if ({r0, r1, lat} !== {32'd14, 32'd2, 32'd33}) begin
            bad++;
            $display("FAIL div: got q0=%0d q1=%0d lat=%0d want 14 2 33", r0, r1, lat);
        end
        run_op(4'd9, 32'd1234, 32'd0, r0, r1, rf, lat);
        total++;
        if ({r0, r1, rf[4], lat} !== {32'hFFFF_FFFF, 32'd1234, 1'b1, 32'd1}) begin
            bad++;
            $display("FAIL div_zero: got q0=%h q1=%0d dz=%b lat=%0d want ffffffff 1234 1 1",
                     r0, r1, rf[4], lat);
        end
`else
        run_op(4'd9, 32'd100, 32'd7, r0, r1, rf, lat);
        total++;
        if ({r0, r1, rf, lat} !== {32'd0, 32'd0, 6'b100000, 32'd1}) begin
            bad++;
            $display("FAIL div_disabled: got q0=%h q1=%h f=%b lat=%0d want 0 0 100000 1",
                     r0, r1, rf, lat);
        end
`endif
    endtask

    task automatic test_random();
        logic [3:0] o;
        logic [31:0] x, y;
        for (int i = 0; i < 40; i++) begin
            o = 4'($urandom_range(0, 15));
            if (i < 10) o = 4'(i);
            x = $urandom;
            y = $urandom;
            if (o == 4'd9) begin
                if ($urandom_range(0, 3) == 0) y = 0;
                else if ($urandom_range(0, 1) == 0) y = $urandom_range(1, 1000);
            end
            check_op("random", o, x, y);
        end
        check_op("shift0", 4'd5, 32'hDEAD_BEEF, 32'd0);
        check_op("shift31", 4'd6, 32'hDEAD_BEEF, 32'd31);
        check_op("mul_zero", 4'd8, 32'd0, 32'h1234_5678);
    endtask

    task automatic test_stall();
        logic [31:0] e0, e1, c0, c1;
        logic [5:0] ef, cf;
        int el, lat, viol;
        model(4'd8, 32'h0001_2345, 32'h0006_789A, e0, e1, ef, el);
        op = 4'd8; a = 32'h0001_2345; b = 32'h0006_789A; in_valid = 1'b1;
        @(posedge clk); #1;
        op = 4'd0; a = 32'd1; b = 32'd1;
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        c0 = q0; c1 = q1; cf = fout;
        total++;
        if ({c0, c1, cf} !== {e0, e1, ef}) begin
            bad++;
            $display("FAIL stall_result: got %h %h %b want %h %h %b", c0, c1, cf, e0, e1, ef);
        end
        viol = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if ({q0, q1, fout} !== {c0, c1, cf} || out_valid !== 1'b1 || in_ready !== 1'b0) viol++;
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("FAIL stall_hold: %0d unstable cycles, want 0", viol);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        total++;
        if ({out_valid, in_ready, q0, q1, fout} !== {1'b0, 1'b1, c0, c1, cf}) begin
            bad++;
            $display("FAIL drain_idle: got ov=%b ir=%b q0=%h want ov=0 ir=1 q0=%h",
                     out_valid, in_ready, q0, c0);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        op = 4'd0; a = 32'd3; b = 32'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        op = 4'd1; a = 32'd10; b = 32'd3; out_ready = 1'b1;
        @(posedge clk); #1;
        total++;
        if ({out_valid, q0} !== {1'b1, 32'd7}) begin
            bad++;
            $display("FAIL b2b_single: got ov=%b q0=%0d want 1 7", out_valid, q0);
        end
        op = 4'd8; a = 32'd6; b = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b0;
        total++;
        if (out_valid !== 1'b0) begin
            bad++;
            $display("FAIL b2b_busy: got ov=%b want 0", out_valid);
        end
        lat = 1;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        total++;
        if ({q0, q1, lat} !== {32'd42, 32'd0, 32'd33}) begin
            bad++;
            $display("FAIL b2b_mul: got q0=%0d q1=%0d lat=%0d want 42 0 33", q0, q1, lat);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_abort();
        int seen;
        op = 4'd8; a = 32'hFFFF_FFFF; b = 32'h1234_5678; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; out_ready = 1'b0;
        total++;
        if ({q0, q1, fout, out_valid, in_ready} !== {32'd0, 32'd0, 6'd0, 1'b0, 1'b1}) begin
            bad++;
            $display("FAIL abort_state: got q0=%h q1=%h f=%b ov=%b ir=%b want zeros ov=0 ir=1",
                     q0, q1, fout, out_valid, in_ready);
        end
        seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        total++;
        if (seen != 0) begin
            bad++;
            $display("FAIL abort_no_result: out_valid seen %0d cycles, want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_stall();
        test_back_to_back();
        test_abort();
        test_directed();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
